// File: rtl/rst_seq_ctrl.sv
// Sequenced reset controller: asserts all reset outputs asynchronously,
// releases them synchronously after a synchroniser plus hold stretch, one
// channel at a time, and re-runs the sequence on a software request.
module rst_seq_ctrl #(
    parameter int NUM_OUT       = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int HOLD_CYCLES   = 4,
    parameter int STAGE_GAP     = 2,
    parameter int SW_RST_CYCLES = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               sw_rst_req_i,
    output logic               sw_rst_ack_o,
    output logic [NUM_OUT-1:0] rst_n_o,
    output logic               rst_done_o
);

    localparam int MAX_HG  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int MAX_CNT = (MAX_HG > SW_RST_CYCLES) ? MAX_HG : SW_RST_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_SW_HOLD
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_OUT-1:0] rst_q;
    logic               done_q;
    logic               ack_q;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_rst_n;
    logic [NUM_OUT-1:0]     rst_shift;

    // Asynchronous assert, synchronous de-assert of the incoming reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_rst_n = sync_q[SYNC_STAGES-1];

    // Releasing the next channel is a shift-in of a 1 from bit 0, which keeps
    // the output vector monotonic by construction; the vector becoming all
    // ones marks the last channel.
    assign rst_shift = NUM_OUT'({rst_q, 1'b1});

    // Sequencing FSM with registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_HOLD: begin
                    if (!sync_rst_n) begin
                        cnt_q <= '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        cnt_q <= '0;
                        rst_q <= rst_shift;
                        if (&rst_shift) begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        rst_q <= rst_shift;
                        if (&rst_shift) begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    cnt_q <= '0;
                    if (sw_rst_req_i) begin
                        rst_q   <= '0;
                        done_q  <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= ST_SW_HOLD;
                    end
                end
                ST_SW_HOLD: begin
                    if (cnt_q == SW_LAST) begin
                        cnt_q <= '0;
                        rst_q <= rst_shift;
                        if (&rst_shift) begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_HOLD;
                    cnt_q   <= '0;
                    rst_q   <= '0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rst_n_o      = rst_q;
    assign rst_done_o   = done_q;
    assign sw_rst_ack_o = ack_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: default instance plus two parameter sweeps.
module tb_rst_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sw0;
    logic       sw_off;
    logic       ack0, ack1, ack2;
    logic [3:0] r0;
    logic [0:0] r1;
    logic [7:0] r2;
    logic       done0, done1, done2;

    typedef struct {
        int         dut;
        logic [7:0] rst;
        logic       done;
        logic       ack;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    rst_seq_ctrl #(.NUM_OUT(4), .SYNC_STAGES(2), .HOLD_CYCLES(4), .STAGE_GAP(2), .SW_RST_CYCLES(8)) u_d0 (
        .clk_i(clk), .rst_n_i(rst_n), .sw_rst_req_i(sw0),
        .sw_rst_ack_o(ack0), .rst_n_o(r0), .rst_done_o(done0));

    rst_seq_ctrl #(.NUM_OUT(1), .SYNC_STAGES(3), .HOLD_CYCLES(1), .STAGE_GAP(3), .SW_RST_CYCLES(8)) u_d1 (
        .clk_i(clk), .rst_n_i(rst_n), .sw_rst_req_i(sw_off),
        .sw_rst_ack_o(ack1), .rst_n_o(r1), .rst_done_o(done1));

    rst_seq_ctrl #(.NUM_OUT(8), .SYNC_STAGES(2), .HOLD_CYCLES(4), .STAGE_GAP(1), .SW_RST_CYCLES(8)) u_d2 (
        .clk_i(clk), .rst_n_i(rst_n), .sw_rst_req_i(sw_off),
        .sw_rst_ack_o(ack2), .rst_n_o(r2), .rst_done_o(done2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected release vector j edges after the reference edge.
    function automatic logic [7:0] seq_exp(int j, int t0, int gap, int n);
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < n; k++)
            if (j >= t0 + k * gap) v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic done_exp(int j, int t0, int gap, int n);
        return (j >= t0 + (n - 1) * gap);
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(int dut, logic [7:0] r, logic d, logic a);
        exp_t e;
        e.dut = dut; e.rst = r; e.done = d; e.ack = a;
        sb.push_back(e);
    endtask

    // Pop every pending expectation and compare against the current outputs.
    task automatic check_all(string tag);
        exp_t       e;
        logic [7:0] o_r;
        logic       o_d, o_a;
        logic [8:0] m;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin o_r = {4'b0, r0}; o_d = done0; o_a = ack0; end
                1:       begin o_r = {7'b0, r1}; o_d = done1; o_a = ack1; end
                default: begin o_r = r2;         o_d = done2; o_a = ack2; end
            endcase
            chk($sformatf("%s.d%0d.rst", tag, e.dut), o_r, e.rst);
            chk($sformatf("%s.d%0d.done", tag, e.dut), {7'b0, o_d}, {7'b0, e.done});
            chk($sformatf("%s.d%0d.ack", tag, e.dut), {7'b0, o_a}, {7'b0, e.ack});
            m = {1'b0, o_r} & ({1'b0, o_r} + 9'd1);
            chk($sformatf("%s.d%0d.mono", tag, e.dut), {7'b0, (m == 9'd0)}, 8'd1);
        end
    endtask

    task automatic step(string tag);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    // Standard power-on trace for the default instance, edges 1..n.
    task automatic std_trace(string tag, int n);
        for (int j = 1; j <= n; j++) begin
            push_exp(0, seq_exp(j, 6, 2, 4), done_exp(j, 6, 2, 4), 1'b0);
            step($sformatf("%s.e%0d", tag, j));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        sw0    = 1'b0;
        sw_off = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state for all instances.
        for (int d = 0; d < 3; d++) push_exp(d, 8'h00, 1'b0, 1'b0);
        check_all("reset");

        // Power-on release between edges; all three instances.
        rst_n = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            push_exp(0, seq_exp(j, 6, 2, 4), done_exp(j, 6, 2, 4), 1'b0);
            push_exp(1, seq_exp(j, 4, 3, 1), done_exp(j, 4, 3, 1), 1'b0);
            push_exp(2, seq_exp(j, 6, 1, 8), done_exp(j, 6, 1, 8), 1'b0);
            step($sformatf("por.e%0d", j));
        end

        // One-cycle software request in RUN.
        sw0 = 1'b1;
        push_exp(0, 8'h00, 1'b0, 1'b1);
        @(posedge clk);
        #1 sw0 = 1'b0;
        @(negedge clk);
        check_all("sw.s0");
        for (int j = 1; j <= 15; j++) begin
            push_exp(0, seq_exp(j, 8, 2, 4), done_exp(j, 8, 2, 4), 1'b0);
            step($sformatf("sw.s%0d", j));
        end

        // Sub-period reset pulse in RUN, then request during RELEASE is ignored.
        #1 rst_n = 1'b0;
        #3;
        push_exp(0, 8'h00, 1'b0, 1'b0);
        check_all("glitch.async");
        rst_n = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            sw0 = (j == 9);
            push_exp(0, seq_exp(j, 6, 2, 4), done_exp(j, 6, 2, 4), 1'b0);
            step($sformatf("glitch.e%0d", j));
        end
        sw0 = 1'b0;

        // Reset asserted mid-sequence at 0011, then full restart.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        std_trace("pre", 8);
        #2 rst_n = 1'b0;
        #1;
        push_exp(0, 8'h00, 1'b0, 1'b0);
        check_all("mid.async");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        std_trace("mid", 14);

        // Held request: accepted, then accepted again on the first RUN edge.
        sw0 = 1'b1;
        push_exp(0, 8'h00, 1'b0, 1'b1);
        step("held.s0");
        for (int j = 1; j <= 15; j++) begin
            if (j == 15) push_exp(0, 8'h00, 1'b0, 1'b1);
            else         push_exp(0, seq_exp(j, 8, 2, 4), done_exp(j, 8, 2, 4), 1'b0);
            step($sformatf("held.s%0d", j));
        end
        sw0 = 1'b0;
        push_exp(0, 8'h00, 1'b0, 1'b0);
        step("held.s16");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Parametrised reset controller that generalises the single synchronous pulse-stretched reset into a multi-channel, sequenced reset generator.
- Asserts all NUM_OUT reset outputs asynchronously, de-asserts them synchronously through a SYNC_STAGES synchroniser and a HOLD_CYCLES stretch, then releases channel 0..NUM_OUT-1 in order, STAGE_GAP cycles apart.
- Also supports a software reset request that re-runs the sequence without toggling rst_n_i.
- Sits at the top of each clock domain and feeds the synchronous resets of downstream blocks.

Parameters:
- NUM_OUT, 4, number of sequenced active-low reset outputs (>=1)
- SYNC_STAGES, 2, synchroniser depth for rst_n_i de-assertion (>=2)
- HOLD_CYCLES, 4, cycles the synchronised reset is stretched before channel 0 releases (>=1)
- STAGE_GAP, 2, cycles between consecutive channel releases (>=1)
- SW_RST_CYCLES, 8, cycles all outputs are held low after an accepted software request (>=1)

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_n_i  input  1  reset, asynchronous, active-low
- sw_rst_req_i  input  1  software reset request, synchronous to clk_i, sampled each edge
- sw_rst_ack_o  output  1  one-cycle pulse, software request accepted
- rst_n_o  output  NUM_OUT  sequenced active-low resets; bit k releases k-th
- rst_done_o  output  1  high when every rst_n_o bit is released (state RUN)

Behaviour:
- Reset (rst_n_i low) acts asynchronously. Synchroniser, counters and FSM are cleared, giving FSM=HOLD, rst_n_o=0, rst_done_o=0, sw_rst_ack_o=0.
- An rst_n_i pulse of any width, including shorter than a clock period, produces a full reset.
- Synchroniser: SYNC_STAGES flops are async-cleared and shift in 1. The internal sync_rst_n goes high at edge SYNC_STAGES, counting edge 1 as the first rising edge after rst_n_i goes high.
- All outputs are registered. rst_n_o is monotonic: if bit k is high, every bit j<k is high.
- FSM states: HOLD, RELEASE, RUN, SW_HOLD.
- HOLD:
  - The counter is cleared while sync_rst_n=0.
  - Once sync_rst_n=1, the block counts HOLD_CYCLES cycles.
  - On the last count it sets rst_n_o[0]=1 and moves to RELEASE with channel index 1.
  - Timing: rst_n_o[0] rises at edge SYNC_STAGES+HOLD_CYCLES. Defaults give edge 6.
- RELEASE:
  - Every STAGE_GAP cycles the next bit is set.
  - Timing: rst_n_o[k] rises at edge T0+k*STAGE_GAP, where T0 is the edge on which rst_n_o[0] rose. Defaults give edges 6, 8, 10, 12.
  - rst_done_o rises on the same edge as rst_n_o[NUM_OUT-1], and the FSM moves to RUN.
  - If NUM_OUT=1, HOLD goes directly to RUN and rst_done_o rises at T0.
- RUN:
  - If sw_rst_req_i=1 at edge S: rst_n_o=0, rst_done_o=0, and sw_rst_ack_o=1 for exactly the one cycle after S. The FSM moves to SW_HOLD.
- SW_HOLD:
  - The block holds for SW_RST_CYCLES cycles.
  - rst_n_o[0] rises at edge S+SW_RST_CYCLES, and the FSM moves to RELEASE; sequencing then follows the RELEASE rules.
  - Defaults: bits rise at S+8, S+10, S+12, S+14, and rst_done_o rises at S+14.
- sw_rst_req_i outside RUN is ignored: no ack and no queuing.
- If sw_rst_req_i is held high, it is accepted again on the first edge the FSM is in RUN, i.e. the edge after rst_done_o rises.
- Asserting rst_n_i mid-sequence (any state) zeros all outputs immediately and restarts from HOLD, with the full synchroniser plus HOLD_CYCLES latency.
- Counter widths are sized from the largest of HOLD_CYCLES, STAGE_GAP and SW_RST_CYCLES. No wrap-around is permitted: each counter clears on every state transition.

Test Plan:
- Power-on, defaults: release rst_n_i between edges -> rst_n_o goes 0000→0001@6→0011@8→0111@10→1111@12; rst_done_o=1@12; no ack.
- rst_n_i low for 3 ns, sub-period, while in RUN -> rst_n_o=0 and rst_done_o=0 asynchronously before the next edge; full sequence repeats from edge 6 after release.
- In RUN, one-cycle sw_rst_req_i at edge S -> rst_n_o=0 and sw_rst_ack_o=1 for one cycle after S; bits release at S+8, S+10, S+12, S+14; rst_done_o@S+14.
- sw_rst_req_i pulsed during RELEASE, after bit 1 is set -> no ack; the sequence completes unchanged at edge 12.
- rst_n_i asserted when rst_n_o=0011 -> immediate 0000; after release, 0001 at edge 6 again, with no partial state retained.
- Parameter sweep NUM_OUT=1, SYNC_STAGES=3, HOLD_CYCLES=1, STAGE_GAP=3 -> rst_n_o[0] and rst_done_o both rise at edge 4. Also check NUM_OUT=8, STAGE_GAP=1 -> bits release on consecutive edges 6..13, and the monotonic property holds every cycle.
